mul16u_err_monitor: RTL and testbench

Sequential error-characterisation stage for the 16x16 unsigned approximate multipliers. It sits directly around a multiplier instance: it drives the multiplier's operand inputs from a valid/ready operand stream and consumes the 32-bit approximate product. It compares each product against an internally computed exact product and accumulates error statistics over a programmable number of samples:

- sum of absolute error (the MAE numerator)
- worst-case absolute error (WCE)
- error count (EP numerator)

The block lets the FPGA evaluation flow measure accuracy in hardware.

---
 rtl/mul16u_err_monitor.sv | 159 +++++++++++++++
 tb/tb_mul16u_err_monitor.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mul16u_err_monitor.sv
// mul16u_err_monitor: drives a 16x16 approximate multiplier from an operand stream and accumulates
// MAE/WCE/EP error statistics. Define ERR_MON_MSE_EN to add the saturating sum-of-squares output.
module mul16u_err_monitor #(
  parameter int NSAMP_W = 16,
  parameter int ACC_W   = 48
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [NSAMP_W-1:0] n_samples,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [15:0]        in_a,
  input  logic [15:0]        in_b,
  output logic [15:0]        mul_a,
  output logic [15:0]        mul_b,
  input  logic [31:0]        mul_o,
  output logic               busy,
  output logic               done,
  output logic [NSAMP_W-1:0] sample_cnt,
  output logic [NSAMP_W-1:0] err_cnt,
  output logic [ACC_W-1:0]   sum_abs_err,
  output logic [31:0]        max_abs_err
`ifdef ERR_MON_MSE_EN
  ,
  output logic [79:0]        sum_sq_err
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]         r_state;
  logic [NSAMP_W-1:0] r_n;
  logic [NSAMP_W-1:0] r_acc_cnt;
  logic               r_s1_v;
  logic               r_s2_v;
  logic [31:0]        r_exact;
  logic [31:0]        r_approx;
  logic               r_done;

  logic               w_start;
  logic               w_accept;
  logic [32:0]        w_d33;
  logic [31:0]        w_abs;
  logic [ACC_W:0]     w_sum_ext;
  logic [ACC_W-1:0]   w_sum_nxt;

  assign in_ready = (r_state == ST_RUN) && (r_acc_cnt < r_n);
  assign busy     = (r_state == ST_RUN);
  assign done     = r_done;
  assign w_start  = start && (r_state == ST_IDLE);
  assign w_accept = in_valid && in_ready;

  // A negative 33-bit difference means approx > exact; two's-complement negate for the magnitude.
  assign w_d33     = {1'b0, r_exact} - {1'b0, r_approx};
  assign w_abs     = w_d33[32] ? (~w_d33[31:0] + 32'd1) : w_d33[31:0];
  assign w_sum_ext = {1'b0, sum_abs_err} + {{(ACC_W-31){1'b0}}, w_abs};
  assign w_sum_nxt = w_sum_ext[ACC_W] ? {ACC_W{1'b1}} : w_sum_ext[ACC_W-1:0];

`ifdef ERR_MON_MSE_EN
  logic [63:0] w_sq;
  logic [80:0] w_sq_ext;
  assign w_sq     = {32'd0, w_abs} * {32'd0, w_abs};
  assign w_sq_ext = {1'b0, sum_sq_err} + {17'd0, w_sq};

  // Sum of squared errors, folded in alongside sum_abs_err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_sq_err <= 80'd0;
    end else if (w_start) begin
      sum_sq_err <= 80'd0;
    end else if (r_s2_v) begin
      sum_sq_err <= w_sq_ext[80] ? {80{1'b1}} : w_sq_ext[79:0];
    end
  end
`endif

  // Campaign FSM; RUN exits on the edge where the last sample leaves S2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_done <= (r_state == ST_DONE);
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state <= (n_samples != {NSAMP_W{1'b0}}) ? ST_RUN : ST_DONE;
          end
        end
        ST_RUN: begin
          if ((r_acc_cnt == r_n) && !r_s1_v) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Operand pipeline: S1 feeds the multiplier, S2 captures approximate and exact products.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n       <= {NSAMP_W{1'b0}};
      r_acc_cnt <= {NSAMP_W{1'b0}};
      r_s1_v    <= 1'b0;
      r_s2_v    <= 1'b0;
      mul_a     <= 16'd0;
      mul_b     <= 16'd0;
      r_exact   <= 32'd0;
      r_approx  <= 32'd0;
    end else begin
      r_s1_v <= w_accept;
      r_s2_v <= r_s1_v;
      if (w_start) begin
        r_n       <= n_samples;
        r_acc_cnt <= {NSAMP_W{1'b0}};
      end else if (w_accept) begin
        r_acc_cnt <= r_acc_cnt + {{(NSAMP_W-1){1'b0}}, 1'b1};
      end
      if (w_accept) begin
        mul_a <= in_a;
        mul_b <= in_b;
      end
      if (r_s1_v) begin
        r_approx <= mul_o;
        r_exact  <= {16'd0, mul_a} * {16'd0, mul_b};
      end
    end
  end

  // Statistics accumulate per S2 sample and hold until the next accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt  <= {NSAMP_W{1'b0}};
      err_cnt     <= {NSAMP_W{1'b0}};
      sum_abs_err <= {ACC_W{1'b0}};
      max_abs_err <= 32'd0;
    end else if (w_start) begin
      sample_cnt  <= {NSAMP_W{1'b0}};
      err_cnt     <= {NSAMP_W{1'b0}};
      sum_abs_err <= {ACC_W{1'b0}};
      max_abs_err <= 32'd0;
    end else if (r_s2_v) begin
      sample_cnt  <= sample_cnt + {{(NSAMP_W-1){1'b0}}, 1'b1};
      if (w_abs != 32'd0) begin
        err_cnt <= err_cnt + {{(NSAMP_W-1){1'b0}}, 1'b1};
      end
      sum_abs_err <= w_sum_nxt;
      if (w_abs > max_abs_err) begin
        max_abs_err <= w_abs;
      end
    end
  end

endmodule

// File: tb/tb_mul16u_err_monitor.sv
// Self-checking bench for mul16u_err_monitor: randomized campaigns against a queue-based reference model.
module tb_mul16u_err_monitor;
  logic        clk = 1'b0;
  logic        rst_n, start, in_valid, in_ready, busy, done;
  logic [15:0] n_samples, sample_cnt, err_cnt, in_a, in_b, mul_a, mul_b;
  logic [31:0] mul_o, max_abs_err;
  logic [47:0] sum_abs_err;
`ifdef ERR_MON_MSE_EN
  logic [79:0] sum_sq_err;
`endif
  int          mode;
  int          errors = 0;
  int          checks = 0;
  logic [15:0] dq_a[$];
  logic [15:0] dq_b[$];

  always #5 clk = ~clk;

  mul16u_err_monitor dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_samples(n_samples),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_o(mul_o), .busy(busy), .done(done),
    .sample_cnt(sample_cnt), .err_cnt(err_cnt), .sum_abs_err(sum_abs_err),
    .max_abs_err(max_abs_err)
`ifdef ERR_MON_MSE_EN
    , .sum_sq_err(sum_sq_err)
`endif
  );

  // Multiplier-under-test stubs: exact, zero, truncated low byte, and exact plus (a^b).
  function automatic logic [31:0] stub(input logic [15:0] a, input logic [15:0] b, input int m);
    logic [31:0] p;
    p = 32'(a) * 32'(b);
    case (m)
      1:       return 32'd0;
      2:       return p & 32'hFFFF_FF00;
      3:       return p + 32'(a ^ b);
      default: return p;
    endcase
  endfunction

  always_comb mul_o = stub(mul_a, mul_b, mode);

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_pair(output logic [15:0] a, output logic [15:0] b);
    if (dq_a.size() > 0) begin
      a = dq_a.pop_front();
      b = dq_b.pop_front();
    end else begin
      a = 16'($urandom);
      b = 16'($urandom);
    end
  endtask

  // One campaign of n samples; vprob is the percentage of cycles with in_valid high.
  task automatic campaign(input int n, input int vprob);
    logic [15:0] qa[$];
    logic [15:0] qb[$];
    int          aedge[$];
    logic [15:0] ca, cb;
    bit          acc, seen;
    int          dedge, exp_cnt, exp_dedge, eerr;
    longint      ex, ap, d, esum, emax;
    logic [79:0] esq;
    @(posedge clk); #1;
    start = 1'b1; n_samples = 16'(n); in_valid = 1'b0;
    next_pair(ca, cb);
    @(posedge clk); #1;  // edge 0: start sampled
    start = 1'b0;
    seen = 1'b0; dedge = -1;
    for (int cyc = 1; cyc < 400 && !seen; cyc++) begin
      in_valid = ($urandom_range(99) < vprob);
      in_a = ca; in_b = cb;
      @(negedge clk);
      if (cyc == 1) chk("busy_after_start", 80'(busy), 80'(n != 0));
      exp_cnt = 0;
      foreach (aedge[i]) if (aedge[i] <= cyc - 3) exp_cnt++;
      chk("in_ready", 80'(in_ready), 80'(aedge.size() < n));
      chk("sample_cnt_run", 80'(sample_cnt), 80'(exp_cnt));
      if (done) begin seen = 1'b1; dedge = cyc - 1; end
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin
        aedge.push_back(cyc); qa.push_back(ca); qb.push_back(cb);
        next_pair(ca, cb);
      end
    end
    in_valid = 1'b0;
    chk("done_seen", 80'(seen), 80'd1);
    exp_dedge = (n == 0 || aedge.size() == 0) ? 1 : aedge[aedge.size()-1] + 3;
    chk("done_edge", 80'(dedge), 80'(exp_dedge));
    chk("accepted", 80'(aedge.size()), 80'(n));
    esum = 0; emax = 0; eerr = 0; esq = 80'd0;
    foreach (qa[i]) begin
      ex = longint'(qa[i]) * longint'(qb[i]);
      ap = longint'(stub(qa[i], qb[i], mode));
      d  = (ex > ap) ? ex - ap : ap - ex;
      esum += d;
      if (d > emax) emax = d;
      if (d != 0) eerr++;
      esq += 80'(d) * 80'(d);
    end
    chk("sample_cnt", 80'(sample_cnt), 80'(n));
    chk("err_cnt", 80'(err_cnt), 80'(eerr));
    chk("sum_abs_err", 80'(sum_abs_err), 80'(esum));
    chk("max_abs_err", 80'(max_abs_err), 80'(emax));
`ifdef ERR_MON_MSE_EN
    chk("sum_sq_err", sum_sq_err, esq);
`endif
    @(negedge clk);
    chk("done_one_cycle", 80'(done), 80'd0);
    chk("busy_idle", 80'(busy), 80'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; n_samples = 16'd0; in_valid = 1'b0;
    in_a = 16'd0; in_b = 16'd0; mode = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 80'(busy), 80'd0);
    chk("rst_done", 80'(done), 80'd0);
    chk("rst_in_ready", 80'(in_ready), 80'd0);
    chk("rst_mul_a", 80'(mul_a), 80'd0);
    chk("rst_sample_cnt", 80'(sample_cnt), 80'd0);
    chk("rst_sum", 80'(sum_abs_err), 80'd0);
    rst_n = 1'b1;

    mode = 0; campaign(4, 70);

    mode = 1;
    dq_a = '{16'hFFFF, 16'd3}; dq_b = '{16'hFFFF, 16'd5};
    campaign(2, 100);
    chk("zero_sum", 80'(sum_abs_err), 80'h0_FFFE_0010);
    chk("zero_max", 80'(max_abs_err), 80'hFFFE_0001);
    chk("zero_err_cnt", 80'(err_cnt), 80'd2);

    mode = 2; campaign(3, 100);
    mode = 3; campaign(20, 60);
    mode = 2; campaign(12, 100);
    mode = 3; campaign(0, 100);
    chk("n0_sum", 80'(sum_abs_err), 80'd0);

`ifdef ERR_MON_MSE_EN
    mode = 1;
    dq_a = '{16'h0100}; dq_b = '{16'h0100};
    campaign(1, 100);
    chk("mse_directed", sum_sq_err, 80'h1_0000_0000);
`endif

    // Reset in the middle of a 5-sample campaign after two accepts.
    mode = 0;
    @(posedge clk); #1;
    start = 1'b1; n_samples = 16'd5;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_a = 16'h1234; in_b = 16'h0F0F;
    @(posedge clk); #1;
    in_a = 16'hABCD;
    @(posedge clk); #2;
    chk("pre_rst_busy", 80'(busy), 80'd1);
    chk("pre_rst_mul_a", 80'(mul_a), 80'hABCD);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 80'(busy), 80'd0);
    chk("mid_rst_in_ready", 80'(in_ready), 80'd0);
    chk("mid_rst_mul_a", 80'(mul_a), 80'd0);
    chk("mid_rst_mul_b", 80'(mul_b), 80'd0);
    chk("mid_rst_done", 80'(done), 80'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    campaign(1, 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
